demux2_16bit_buf: RTL and testbench

Buffered 1-to-2 demultiplexer for 16-bit datapath words: routes each accepted input word `X` to output channel A (`sel`=0) or channel B (`sel`=1). It is the counterpart to `mux2_16bit`: the mux selects between two operand sources, and this block steers one ALU result back out to two destinations. Each channel has a one-entry holding register with a valid/ready handshake, so a stalled destination never corrupts or drops data. Per-channel delivery counters support debug and verification.

---
 rtl/demux2_16bit_buf_if.sv | 67 ++++++
 rtl/demux2_16bit_buf.sv | 122 ++++++++++++
 tb/tb_demux2_16bit_buf.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux2_16bit_buf_if.sv
`default_nettype none
// ============================================================================
//  Module      : demux2_16bit_buf_if
//  Description : Bundle of the data, handshake and counter signals of the
//                buffered 1-to-2 demultiplexer.
//                  X, sel, in_valid / in_ready   : producer side
//                  A, A_valid / A_ready, A_count : channel A consumer side
//                  B, B_valid / B_ready, B_count : channel B consumer side
//                Modport "slave" is the demultiplexer itself, modport
//                "master" is the environment that feeds it and drains it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface demux2_16bit_buf_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    // Producer side
    logic [WIDTH-1:0] X;
    logic             sel;
    logic             in_valid;
    logic             in_ready;

    // Channel A
    logic [WIDTH-1:0] A;
    logic             A_valid;
    logic             A_ready;
    logic [CNT_W-1:0] A_count;

    // Channel B
    logic [WIDTH-1:0] B;
    logic             B_valid;
    logic             B_ready;
    logic [CNT_W-1:0] B_count;

    // The demultiplexer
    modport slave (
        input  X,
        input  sel,
        input  in_valid,
        output in_ready,
        output A,
        output A_valid,
        input  A_ready,
        output A_count,
        output B,
        output B_valid,
        input  B_ready,
        output B_count
    );

    // Whoever drives words in and consumes them
    modport master (
        output X,
        output sel,
        output in_valid,
        input  in_ready,
        input  A,
        input  A_valid,
        output A_ready,
        input  A_count,
        input  B,
        input  B_valid,
        output B_ready,
        input  B_count
    );
endinterface : demux2_16bit_buf_if
`default_nettype wire

// File: rtl/demux2_16bit_buf.sv
`default_nettype none
// ============================================================================
//  Module      : demux2_16bit_buf
//  Description : Buffered 1-to-2 demultiplexer. Each accepted word X is
//                steered to channel A (sel=0) or channel B (sel=1), where it
//                sits in a one-entry holding register until that channel's
//                consumer takes it with a valid/ready handshake. Per-channel
//                delivery counters (modulo 2^CNT_W) are provided for debug.
//  Ports       : clk   - single clock, rising edge
//                rst_n - synchronous active-low reset
//                bus   - demux2_16bit_buf_if.slave (X/sel/in_valid/in_ready,
//                        A/A_valid/A_ready/A_count, B/B_valid/B_ready/B_count)
//  Revision    : 1.0 - initial release
// ============================================================================
module demux2_16bit_buf #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    demux2_16bit_buf_if.slave       bus
);

    localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_zero = '0;
    localparam logic [WIDTH-1:0] c_data_zero = '0;

    // ------------------------------------------------------------------
    // Holding registers and counters
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_a_data;
    logic             r_a_valid;
    logic [CNT_W-1:0] r_a_count;

    logic [WIDTH-1:0] r_b_data;
    logic             r_b_valid;
    logic [CNT_W-1:0] r_b_count;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic w_a_free;
    logic w_b_free;
    logic w_in_ready;
    logic w_acc;
    logic w_load_a;
    logic w_load_b;
    logic w_deliver_a;
    logic w_deliver_b;

    // A channel can take a new word when it is empty or is being drained
    // this very cycle; only the selected channel gates the producer, so a
    // stalled channel never blocks traffic headed to the other one.
    assign w_a_free   = ~r_a_valid | bus.A_ready;
    assign w_b_free   = ~r_b_valid | bus.B_ready;
    assign w_in_ready = bus.sel ? w_b_free : w_a_free;

    assign w_acc       = bus.in_valid & w_in_ready;
    assign w_load_a    = w_acc & ~bus.sel;
    assign w_load_b    = w_acc &  bus.sel;
    assign w_deliver_a = r_a_valid & bus.A_ready;
    assign w_deliver_b = r_b_valid & bus.B_ready;

    // ------------------------------------------------------------------
    // Channel A
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_data  <= c_data_zero;
            r_a_valid <= 1'b0;
            r_a_count <= c_cnt_zero;
        end else begin
            // A load wins over a drain: the drained word leaves and the new
            // one takes its place, so valid stays high across the swap.
            if (w_load_a) begin
                r_a_data  <= bus.X;
                r_a_valid <= 1'b1;
            end else if (w_deliver_a) begin
                r_a_valid <= 1'b0;
            end

            if (w_deliver_a) begin
                r_a_count <= r_a_count + c_cnt_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Channel B
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_b_data  <= c_data_zero;
            r_b_valid <= 1'b0;
            r_b_count <= c_cnt_zero;
        end else begin
            if (w_load_b) begin
                r_b_data  <= bus.X;
                r_b_valid <= 1'b1;
            end else if (w_deliver_b) begin
                r_b_valid <= 1'b0;
            end

            if (w_deliver_b) begin
                r_b_count <= r_b_count + c_cnt_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready = w_in_ready;
    assign bus.A        = r_a_data;
    assign bus.A_valid  = r_a_valid;
    assign bus.A_count  = r_a_count;
    assign bus.B        = r_b_data;
    assign bus.B_valid  = r_b_valid;
    assign bus.B_count  = r_b_count;

endmodule : demux2_16bit_buf
`default_nettype wire

// File: tb/tb_demux2_16bit_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux2_16bit_buf
//  Description : Self-checking bench for demux2_16bit_buf. Directed scenario
//                tasks followed by a randomized run scored against a
//                queue-based reference model of the two channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux2_16bit_buf;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    demux2_16bit_buf_if #(.WIDTH(16), .CNT_W(8)) bus ();

    demux2_16bit_buf #(.WIDTH(16), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after the falling edge; everything is observed
    // 1 time unit later, well away from the rising edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic [15:0] x, input logic s, input logic iv,
                          input logic ar, input logic br);
        bus.X        = x;
        bus.sel      = s;
        bus.in_valid = iv;
        bus.A_ready  = ar;
        bus.B_ready  = br;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        set_in(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        #1;
        n_cmp++;
        if (bus.A !== 16'd0 || bus.B !== 16'd0) begin
            n_err++; $display("FAIL reset_data: A=%h B=%h want 0 0", bus.A, bus.B);
        end
        n_cmp++;
        if (bus.A_valid !== 1'b0 || bus.B_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: A_valid=%b B_valid=%b want 0 0", bus.A_valid, bus.B_valid);
        end
        n_cmp++;
        if (bus.A_count !== 8'd0 || bus.B_count !== 8'd0) begin
            n_err++; $display("FAIL reset_count: A_count=%0d B_count=%0d want 0 0", bus.A_count, bus.B_count);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_basic_a();
        do_reset();
        set_in(16'd40, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL basic_in_ready: got %b want 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus.A !== 16'd40 || bus.A_valid !== 1'b1 || bus.B_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_load: A=%0d A_valid=%b B_valid=%b want 40 1 0", bus.A, bus.A_valid, bus.B_valid);
        end
        tick();
        #1;
        n_cmp++;
        if (bus.A_valid !== 1'b0 || bus.A_count !== 8'd1) begin
            n_err++; $display("FAIL basic_deliver: A_valid=%b A_count=%0d want 0 1", bus.A_valid, bus.A_count);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_hold_b();
        do_reset();
        set_in(16'd33, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        tick();
        #1;
        n_cmp++;
        if (bus.B !== 16'd33 || bus.B_valid !== 1'b1) begin
            n_err++; $display("FAIL hold_b: B=%0d B_valid=%b want 33 1", bus.B, bus.B_valid);
        end
        set_in(16'd55, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_err++; $display("FAIL hold_b_stall: in_ready=%b want 0", bus.in_ready);
        end
        tick();
        #1;
        n_cmp++;
        if (bus.B !== 16'd33 || bus.B_valid !== 1'b1) begin
            n_err++; $display("FAIL hold_b_kept: B=%0d B_valid=%b want 33 1", bus.B, bus.B_valid);
        end
        set_in(16'd40, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL hold_b_a_ready: in_ready=%b want 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus.A !== 16'd40 || bus.A_valid !== 1'b1 || bus.B !== 16'd33 || bus.B_valid !== 1'b1) begin
            n_err++; $display("FAIL hold_b_a_load: A=%0d A_valid=%b B=%0d B_valid=%b want 40 1 33 1",
                              bus.A, bus.A_valid, bus.B, bus.B_valid);
        end
        bus.B_ready = 1'b1;
        tick();
        bus.B_ready = 1'b0;
        #1;
        n_cmp++;
        if (bus.B_valid !== 1'b0 || bus.B_count !== 8'd1 || bus.A_count !== 8'd0 || bus.A_valid !== 1'b1) begin
            n_err++; $display("FAIL hold_b_drain: B_valid=%b B_count=%0d A_count=%0d A_valid=%b want 0 1 0 1",
                              bus.B_valid, bus.B_count, bus.A_count, bus.A_valid);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        do_reset();
        for (int w = 1; w <= 4; w++) begin
            set_in(16'(w), 1'b1, 1'b1, 1'b0, 1'b1);
            tick();
            #1;
            n_cmp++;
            if (bus.B !== 16'(w) || bus.B_valid !== 1'b1 || bus.B_count !== 8'(w - 1)) begin
                n_err++; $display("FAIL stream_b_%0d: B=%0d B_valid=%b B_count=%0d want %0d 1 %0d",
                                  w, bus.B, bus.B_valid, bus.B_count, w, w - 1);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        #1;
        n_cmp++;
        if (bus.B_valid !== 1'b0 || bus.B_count !== 8'd4 || bus.A_count !== 8'd0) begin
            n_err++; $display("FAIL stream_b_end: B_valid=%b B_count=%0d A_count=%0d want 0 4 0",
                              bus.B_valid, bus.B_count, bus.A_count);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_wrap();
        do_reset();
        for (int k = 1; k <= 256; k++) begin
            set_in(16'(k), 1'b0, 1'b1, 1'b1, 1'b0);
            tick();
        end
        bus.in_valid = 1'b0;
        #1;
        // 256 accepted, 255 delivered so far
        n_cmp++;
        if (bus.A_count !== 8'd255 || bus.A !== 16'd256 || bus.A_valid !== 1'b1) begin
            n_err++; $display("FAIL wrap_255: A_count=%0d A=%0d A_valid=%b want 255 256 1",
                              bus.A_count, bus.A, bus.A_valid);
        end
        tick();
        #1;
        n_cmp++;
        if (bus.A_count !== 8'd0 || bus.A_valid !== 1'b0 || bus.B_count !== 8'd0) begin
            n_err++; $display("FAIL wrap_0: A_count=%0d A_valid=%b B_count=%0d want 0 0 0",
                              bus.A_count, bus.A_valid, bus.B_count);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_mid_reset();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_in(16'(k + 100), 1'b0, 1'b1, 1'b1, 1'b0);
            tick();
        end
        set_in(16'h1234, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        set_in(16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (bus.A !== 16'h1234 || bus.A_valid !== 1'b1 || bus.A_count !== 8'd5) begin
            n_err++; $display("FAIL midrst_pre: A=%h A_valid=%b A_count=%0d want 1234 1 5",
                              bus.A, bus.A_valid, bus.A_count);
        end
        rst_n = 1'b0;
        set_in(16'hBEEF, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        rst_n = 1'b1;
        set_in(16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (bus.A !== 16'd0 || bus.A_valid !== 1'b0 || bus.A_count !== 8'd0) begin
            n_err++; $display("FAIL midrst_a: A=%h A_valid=%b A_count=%0d want 0 0 0",
                              bus.A, bus.A_valid, bus.A_count);
        end
        n_cmp++;
        if (bus.B_valid !== 1'b0 || bus.B !== 16'd0 || bus.B_count !== 8'd0) begin
            n_err++; $display("FAIL midrst_no_accept: B=%h B_valid=%b B_count=%0d want 0 0 0",
                              bus.B, bus.B_valid, bus.B_count);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_drain_load();
        do_reset();
        set_in(16'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(16'd9, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (bus.A !== 16'd7 || bus.A_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL drainload_pre: A=%0d A_valid=%b in_ready=%b want 7 1 1",
                              bus.A, bus.A_valid, bus.in_ready);
        end
        tick();
        set_in(16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (bus.A !== 16'd9 || bus.A_valid !== 1'b1 || bus.A_count !== 8'd1) begin
            n_err++; $display("FAIL drainload: A=%0d A_valid=%b A_count=%0d want 9 1 1",
                              bus.A, bus.A_valid, bus.A_count);
        end
    endtask

    // ------------------------------------------------------------------
    // Random traffic against a model that sees each channel as a FIFO of
    // undelivered words (capacity one) plus a delivered-word tally.
    task automatic test_random();
        logic [15:0] qa[$];
        logic [15:0] qb[$];
        int          ca;
        int          cb;
        logic [15:0] x;
        logic        s, iv, ar, br, r, exp_rdy;

        do_reset();
        ca = 0;
        cb = 0;
        for (int n = 0; n < 600; n++) begin
            x  = 16'($urandom);
            s  = 1'($urandom_range(0, 1));
            iv = ($urandom_range(0, 3) != 0);
            ar = ($urandom_range(0, 2) != 0);
            br = ($urandom_range(0, 2) != 0);
            r  = ($urandom_range(0, 63) != 0);
            rst_n = r;
            set_in(x, s, iv, ar, br);
            #1;
            exp_rdy = s ? (qb.size() == 0 || br) : (qa.size() == 0 || ar);
            n_cmp++;
            if (bus.in_ready !== exp_rdy) begin
                n_err++; $display("FAIL rand_in_ready[%0d]: got %b want %b", n, bus.in_ready, exp_rdy);
            end

            if (!r) begin
                qa.delete();
                qb.delete();
                ca = 0;
                cb = 0;
            end else begin
                if (qa.size() != 0 && ar) begin
                    void'(qa.pop_front());
                    ca = (ca + 1) % 256;
                end
                if (qb.size() != 0 && br) begin
                    void'(qb.pop_front());
                    cb = (cb + 1) % 256;
                end
                if (iv && exp_rdy) begin
                    if (s) qb.push_back(x);
                    else   qa.push_back(x);
                end
            end

            tick();
            #1;
            n_cmp++;
            if (bus.A_valid !== (qa.size() != 0) || (qa.size() != 0 && bus.A !== qa[0])) begin
                n_err++; $display("FAIL rand_a[%0d]: A=%h A_valid=%b want valid=%0d word=%h",
                                  n, bus.A, bus.A_valid, qa.size(), (qa.size() != 0) ? qa[0] : 16'h0);
            end
            n_cmp++;
            if (bus.B_valid !== (qb.size() != 0) || (qb.size() != 0 && bus.B !== qb[0])) begin
                n_err++; $display("FAIL rand_b[%0d]: B=%h B_valid=%b want valid=%0d word=%h",
                                  n, bus.B, bus.B_valid, qb.size(), (qb.size() != 0) ? qb[0] : 16'h0);
            end
            n_cmp++;
            if (bus.A_count !== 8'(ca) || bus.B_count !== 8'(cb)) begin
                n_err++; $display("FAIL rand_count[%0d]: A_count=%0d B_count=%0d want %0d %0d",
                                  n, bus.A_count, bus.B_count, ca, cb);
            end
            if (!r) begin
                n_cmp++;
                if (bus.A !== 16'd0 || bus.B !== 16'd0) begin
                    n_err++; $display("FAIL rand_rst_data[%0d]: A=%h B=%h want 0 0", n, bus.A, bus.B);
                end
            end
        end
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        set_in(16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_basic_a();
        test_hold_b();
        test_back_to_back();
        test_wrap();
        test_mid_reset();
        test_drain_load();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule : tb_demux2_16bit_buf
`default_nettype wire
